// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and sizing helpers for the chunk-serial adder
package arith_pkg;

  // FSM state encoding shared by the adder and anything that observes it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of add cycles needed for one operation
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-chunk adder still needs a 1-bit index
  function automatic int idx_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_cycle_adder_if.sv
// rtl/multi_cycle_adder_if.sv - operand/result handshake bundle for multi_cycle_adder
interface multi_cycle_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Requester side: issues operands and consumes the result
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CHUNK-bit ripple adder built from full_adder cells
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;
  assign cout = c[CHUNK];

  // Ripple chain: each cell feeds its carry to the next more significant bit
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multi_cycle_adder.sv
// rtl/multi_cycle_adder.sv - chunk-serial add/subtract with valid/ready on both sides
module multi_cycle_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                 clk,
  input logic                 rst,
  multi_cycle_adder_if.slave  bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(WIDTH, CHUNK);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             last_chunk;

  // Select the operand slice for the chunk currently being summed
  always_comb begin
    a_chunk    = op_a[int'(idx) * CHUNK +: CHUNK];
    b_chunk    = op_b[int'(idx) * CHUNK +: CHUNK];
    last_chunk = (idx == IW'(NCHUNK - 1));
  end

  adder_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (a_chunk),
    .b   (b_chunk),
    .cin (carry),
    .s   (s_chunk),
    .cout(c_chunk)
  );

  // Control FSM with operand capture, per-chunk accumulation and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      idx         <= '0;
      carry       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a       <= bus.a;
            // Subtraction is a + ~b + 1, so the borrow-in becomes a forced carry of 1
            op_b       <= bus.sub ? ~bus.b : bus.b;
            carry      <= bus.sub | bus.cin;
            idx        <= '0;
            state      <= ADD;
            in_ready_q <= 1'b0;
          end
        end
        ADD: begin
          sum_q[int'(idx) * CHUNK +: CHUNK] <= s_chunk;
          carry <= c_chunk;
          if (last_chunk) begin
            cout_q      <= c_chunk;
            // Signed overflow uses the effective (possibly inverted) B operand
            ovf_q       <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                           (s_chunk[CHUNK-1] != op_a[WIDTH-1]);
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb/tb_multi_cycle_adder.sv - directed and randomised checks for multi_cycle_adder
module tb_multi_cycle_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  multi_cycle_adder_if #(.WIDTH(16)) bus16 ();
  multi_cycle_adder_if #(.WIDTH(8))  bus8 ();

  multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk),
    .rst(rst),
    .bus(bus16.slave)
  );

  multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    if (sel == 0) begin
      bus16.in_valid = v; bus16.a = a; bus16.b = b; bus16.cin = c; bus16.sub = s;
    end else begin
      bus8.in_valid = v; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = c; bus8.sub = s;
    end
  endtask

  task automatic set_ready(input int sel, input logic r);
    if (sel == 0) bus16.out_ready = r;
    else          bus8.out_ready  = r;
  endtask

  // {in_ready, out_valid, cout, ovf, sum[15:0]}
  function automatic logic [19:0] peek(input int sel);
    if (sel == 0) return {bus16.in_ready, bus16.out_valid, bus16.cout, bus16.ovf, bus16.sum};
    else          return {bus8.in_ready, bus8.out_valid, bus8.cout, bus8.ovf, 8'h00, bus8.sum};
  endfunction

  task automatic run_op(input int sel, input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic [15:0] esum,
                        input logic ec, input logic eo, input int elat);
    logic [19:0] p;
    int n;
    p = peek(sel);
    check({tag, "_in_ready_before"}, 32'(p[19]), 32'd1);
    drive(sel, 1'b1, a, b, c, s);
    tick;
    drive(sel, 1'b0, a, b, c, s);
    n = 0;
    p = peek(sel);
    while (!p[18] && n < 20) begin
      tick;
      n++;
      p = peek(sel);
    end
    check({tag, "_latency"}, 32'(n), 32'(elat));
    check({tag, "_sum"}, 32'(p[15:0]), 32'(esum));
    check({tag, "_cout"}, 32'(p[17]), 32'(ec));
    check({tag, "_ovf"}, 32'(p[16]), 32'(eo));
    check({tag, "_in_ready_busy"}, 32'(p[19]), 32'd0);
    set_ready(sel, 1'b1);
    tick;
    set_ready(sel, 1'b0);
    p = peek(sel);
    check({tag, "_in_ready_after"}, 32'(p[19]), 32'd1);
    check({tag, "_out_valid_after"}, 32'(p[18]), 32'd0);
  endtask

  initial begin
    logic [19:0] p;
    logic        seen_valid;
    logic [7:0]  ra, rb, rob;
    logic        rc, rs;
    logic [8:0]  rres;
    logic        rovf;

    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_ready(0, 1'b0);
    set_ready(1, 1'b0);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;

    p = peek(0);
    check("reset_in_ready", 32'(p[19]), 32'd1);
    check("reset_out_valid", 32'(p[18]), 32'd0);
    check("reset_cout_ovf", 32'(p[17:16]), 32'd0);
    check("reset_sum", 32'(p[15:0]), 32'd0);

    run_op(0, "add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4);
    run_op(0, "wrap_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    run_op(0, "ovf_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
    run_op(0, "cin_add", 16'h1000, 16'h0FFF, 1'b1, 1'b0, 16'h2000, 1'b0, 1'b0, 4);
    run_op(0, "sub_5m7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4);
    run_op(0, "sub_8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4);

    // Backpressure: result held while out_ready=0, stray in_valid ignored
    drive(0, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
    tick;
    drive(0, 1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    tick; tick; tick; tick;
    p = peek(0);
    check("bp_out_valid", 32'(p[18]), 32'd1);
    check("bp_sum", 32'(p[15:0]), 32'h5555);
    drive(0, 1'b1, 16'hAAAA, 16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      p = peek(0);
      check("bp_stall_sum", 32'(p[15:0]), 32'h5555);
      check("bp_stall_flags", 32'(p[19:16]), 32'b0100);
    end
    drive(0, 1'b0, 16'hAAAA, 16'h1111, 1'b0, 1'b0);
    set_ready(0, 1'b1);
    tick;
    set_ready(0, 1'b0);
    p = peek(0);
    check("bp_release_in_ready", 32'(p[19]), 32'd1);
    check("bp_release_out_valid", 32'(p[18]), 32'd0);
    check("bp_release_sum_held", 32'(p[15:0]), 32'h5555);
    tick;
    p = peek(0);
    check("bp_no_stray_accept", 32'(p[19]), 32'd1);

    // Reset during the second ADD cycle
    drive(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    tick;
    drive(0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    p = peek(0);
    check("rst_mid_in_ready", 32'(p[19]), 32'd1);
    check("rst_mid_out_valid", 32'(p[18]), 32'd0);
    check("rst_mid_cout_ovf", 32'(p[17:16]), 32'd0);
    check("rst_mid_sum", 32'(p[15:0]), 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      p = peek(0);
      seen_valid = seen_valid | p[18];
    end
    check("rst_mid_no_valid", 32'(seen_valid), 32'd0);
    run_op(0, "post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 4);

    // Degenerate single-chunk configuration
    run_op(1, "deg_c8", 16'h00C8, 16'h0064, 1'b0, 1'b0, 16'h002C, 1'b1, 1'b0, 1);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'(i & 1);
      if (rs) begin
        rob  = ~rb;
        rres = {1'b0, ra} + {1'b0, rob} + 9'd1;
      end else begin
        rob  = rb;
        rres = {1'b0, ra} + {1'b0, rob} + {8'd0, rc};
      end
      rovf = (ra[7] == rob[7]) && (rres[7] != ra[7]);
      run_op(1, "rand8", {8'h00, ra}, {8'h00, rb}, rc, rs, {8'h00, rres[7:0]}, rres[8], rovf, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_adder.md
Name: multi_cycle_adder

Overview:
- Parametrised, chunk-serial adder/subtractor. It is the sequential successor to the team's single-bit adder cell.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register.
- Valid/ready handshake on both sides, so it drops into arithmetic datapaths where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits summed per clock cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived (localparam), number of add cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/mode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset values (on the rst edge): state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, chunk index=0, carry reg=0.
- rst has priority over every other event and aborts any operation in flight. The partial result is discarded and no out_valid pulse follows.
- States: IDLE, ADD, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE:
  - On an edge with in_valid=1, latch a into op_a.
  - Latch op_b = sub ? ~b : b.
  - Set carry = sub ? 1 : cin, idx = 0, and go to ADD.
  - in_valid=0 keeps the block in IDLE.
- ADD: each edge computes {c, s} = op_a[idx chunk] + op_b[idx chunk] + carry.
  - Write s into sum[idx*CHUNK +: CHUNK] and set carry <= c.
  - When idx==NCHUNK-1: set cout <= c, set ovf per the rule below, and go to DONE. Otherwise idx <= idx+1.
  - Inputs are ignored during ADD, since in_ready=0.
- ovf = (op_a[MSB]==op_b[MSB]) && (final sum[MSB] != op_a[MSB]), using the effective (possibly inverted) op_b.
- DONE:
  - sum, cout and ovf are held stable while out_ready=0, with no limit on the stall.
  - An edge with out_ready=1 returns the block to IDLE. sum, cout and ovf keep their values until the next operation overwrites them.
- Latency: out_valid rises exactly NCHUNK edges after the accepting edge.
- Throughput: no accept in the same cycle as result hand-off. Minimum spacing between accepts is NCHUNK+2 cycles.
- CHUNK==WIDTH is legal: a single ADD cycle, latency 1.
- sum bits of chunks not yet processed are don't-care internally, but they are never visible because out_valid=0 until DONE.
- No arithmetic is widened beyond CHUNK+1 bits per cycle. cout and ovf come only from the final chunk.

Decomposition:
- Shared package (arith_pkg) holds:
  - the state encoding constants (IDLE=2'd0, ADD=2'd1, DONE=2'd2);
  - a helper constant/function for NCHUNK and the index width, clog2(NCHUNK), minimum 1.
- One natural sub-module, adder_chunk: combinational CHUNK-bit ripple adder (a, b, cin -> s, cout), built as a chain of the team's single-bit adder cells.
- The FSM, operand registers and chunk indexing stay in multi_cycle_adder.

Test Plan:
1. WIDTH=16, CHUNK=4: a=0x00FF, b=0x0001, cin=0, sub=0 -> after 4 cycles out_valid=1, sum=0x0100, cout=0, ovf=0.
2. Carry wrap: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
3. Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/ovf stable and in_ready=0 throughout. Pulse out_ready=1 -> IDLE next edge, in_ready=1. Any in_valid raised during the stall is not accepted.
5. Reset mid-operation: assert rst on the 2nd ADD cycle -> next edge all outputs at reset values, in_ready=1, and no out_valid appears. A fresh op 0x1234+0x1111 then gives 0x2345.
6. Degenerate CHUNK=WIDTH=8: a=0xC8, b=0x64 -> out_valid one edge after accept, sum=0x2C, cout=1, ovf=0. Then run 200 random ops against a reference model for both sub values.
